mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Sequential shift-and-add multiplier controller. It time-shares one W-bit ripple adder across W step cycles to form an unsigned W×W product, with a start/busy/done handshake. It sits between the switch-input front end and the BCD/7-segment display encoders. It replaces the fully unrolled adder-array multiplier wherever area matters more than single-cycle latency.

## Interface
Parameters:
- W, 3, operand width in bits (2 ≤ W ≤ 8); product is 2W bits.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  W  multiplicand, captured when start is accepted.
- b  in  W  multiplier, captured when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse while in DONE.
- product  out  2W  last completed result; held until the next completion.

## Operation
- States: IDLE, RUN, DONE. State encoding is binary.
- Working registers:
  - mcand (W bits)
  - P (2W+1 bits): hi part P[2W:W], lo part P[W-1:0]
  - cnt (counts 0..W-1)
- Behaviour in each state:
  - IDLE and start=1: mcand←a; P←{(W+1)'b0, b}; cnt←0; go to RUN. IDLE and start=0: hold.
  - RUN, each edge performs one step:
    - if P[0]=1: sum = P[2W-1:W] + mcand through the shared adder, carry-out into bit W. Otherwise sum = {1'b0, P[2W-1:W]}.
    - P ← {1'b0, sum, P[W-1:1]}, a logical right shift with sum inserted above the lo part.
    - cnt←cnt+1.
    - On the step where cnt=W-1: product←new P[2W-1:0] and go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start in RUN or DONE is ignored. It is not queued.
- a and b may change freely after the capture edge; they do not affect the result in flight.
- Arithmetic is unsigned. The product always fits in 2W bits, so there is no overflow output.
- P[2W] is always 0 after each shift; it exists only to hold the adder carry before the shift.
- Zero operands take the same number of cycles; there is no early exit.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE
  - busy=0, done=0, product=0
  - mcand=0, P=0, cnt=0
- Release of rst_n is treated as synchronous to CLOCK_50; the first start is sampled on the first edge after release.
- Latency, with E0 the edge that samples start=1 in IDLE:
  - busy is high from E0 to E_W.
  - Steps occur at E1..E_W.
  - product updates at E_W.
  - done is high from E_W to E_W+1.
  - State returns to IDLE at E_W+1.
- Throughput: the next start can be accepted at E_W+2 at the earliest, giving W+2 cycles per operation.
- start held high continuously gives back-to-back operations every W+2 cycles, with fresh a and b captured each time.
- busy and done are never high together. done is never high for two consecutive cycles.
- Reset asserted mid-RUN aborts the operation: product returns to 0 and no done pulse is produced.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Structure
- Shared package mul_pkg:
  - state typedef/localparams ST_IDLE, ST_RUN, ST_DONE
  - the default width constant MUL_W=3
- One sub-module, ripple_add: W-bit ripple-carry adder built from per-bit full adders.
  - Inputs x[W-1:0], y[W-1:0], cin.
  - Outputs s[W-1:0], cout.
  - Instantiated once, with cin tied to 0.
- The controller holds the FSM, counter and shift register. The display encoders remain separate top-level instances.

## Test plan
- Reset then a=7, b=7, W=3, start pulsed at E0 → busy high for 3 cycles, done pulses once right after E3, product=49 (0x31), busy=0 in the done cycle.
- a=5, b=0 then a=0, b=6, sequentially → each takes W+2 cycles and gives product=0; done pulses once per operation.
- start held high for 20 cycles, a=3, b=6 → exactly 4 operations complete, one every 5 cycles, each product=18. The start cycles that fall in RUN or DONE do not alter timing.
- Start accepted with a=6, b=5; a and b change to 1 and 1 during RUN → product=30, not 1.
- rst_n driven low asynchronously mid-RUN (between edges, after E1) → outputs immediately 0 with state IDLE. After release, no done pulse follows, and a new start with a=2, b=3 completes with product=6.
- Exhaustive sweep of all 64 (a,b) pairs at W=3, plus a W=4 instance with a=15, b=15 → every product equals a·b (W=4: 225); latency is always W cycles from the sample edge to done.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

  // Default operand width.
  localparam int unsigned MUL_W = 3;

  // Controller states, binary encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_add.sv
// W-bit ripple-carry adder built from per-bit full adders.
module ripple_add #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier: one shared W-bit adder used over W step cycles.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic           CLOCK_50,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [2*W:0]     p_q, p_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0]   product_q, product_d;

  logic [W-1:0]     add_s;
  logic             add_cout;
  logic [W:0]       sum;

  // P[2W] only carries the adder carry before the shift; it is never read back.
  logic             unused_p_top;
  assign unused_p_top = p_q[2*W];

  ripple_add #(
    .W (W)
  ) u_add (
    .x    (p_q[2*W-1:W]),
    .y    (mcand_q),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // Add the multiplicand into the hi part only when the current lo bit is set.
  always_comb begin
    sum = {1'b0, p_q[2*W-1:W]};
    if (p_q[0]) begin
      sum = {add_cout, add_s};
    end
  end

  // Next-state logic: capture in IDLE, one shift-add step per RUN cycle, DONE lasts one cycle.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          p_d     = {{(W+1){1'b0}}, b};
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d   = {1'b0, sum, p_q[W-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          product_d = p_d[2*W-1:0];
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    product = product_q;
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: W=3 instance with a cycle model and scoreboard,
// plus a directed W=4 instance.
module tb_mul_seq_ctrl;

  localparam int W = 3;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  logic           start4;
  logic [3:0]     a4, b4;
  logic           busy4, done4;
  logic [7:0]     product4;

  int n_vec;
  int n_bad;
  int done_cnt;

  // Expected products, pushed when the model accepts a start.
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_exp;

  // Reference cycle model: 0 idle, 1 run, 2 done.
  int m_st;
  int m_k;

  mul_seq_ctrl #(
    .W (W)
  ) u_dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  mul_seq_ctrl #(
    .W (4)
  ) u_dut4 (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .a        (a4),
    .b        (b4),
    .busy     (busy4),
    .done     (done4),
    .product  (product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the handshake timing; pushes a*b on each accepted start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0;
      m_k  <= 0;
    end else begin
      case (m_st)
        0: if (start) begin
          sb.push_back({3'b000, a} * {3'b000, b});
          m_st <= 1;
          m_k  <= 0;
        end
        1: begin
          m_k <= m_k + 1;
          if (m_k == W - 1) m_st <= 2;
        end
        default: m_st <= 0;
      endcase
    end
  end

  // Monitor on the falling edge: flags every cycle, product popped on done.
  always @(negedge clk or negedge rst_n) begin
    logic [2*W-1:0] exp_v;
    if (!rst_n) begin
      last_exp <= '0;
      sb.delete();
    end else begin
      check("busy", 32'(busy), 32'(m_st == 1));
      check("done", 32'(done), 32'(m_st == 2));
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          exp_v = sb.pop_front();
          check("product", 32'(product), 32'(exp_v));
          last_exp <= exp_v;
        end
      end else begin
        check("product_hold", 32'(product), 32'(last_exp));
      end
    end
  end

  // One operation: start for a single cycle, then change operands while it runs.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] a_after, input logic [W-1:0] b_after);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = a_after;
    b     = b_after;
    repeat (W + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int cyc;
    n_vec    = 0;
    n_bad    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    start4   = 1'b0;
    a4       = '0;
    b4       = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_product", 32'(product), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 7*7 = 49
    do_op(3'd7, 3'd7, 3'd0, 3'd0);
    // Zero operands still take the full latency.
    do_op(3'd5, 3'd0, 3'd0, 3'd0);
    do_op(3'd0, 3'd6, 3'd0, 3'd0);

    // start held for 20 edges: four back-to-back operations.
    base  = done_cnt;
    start = 1'b1;
    a     = 3'd3;
    b     = 3'd6;
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("held_start_ops", 32'(done_cnt - base), 32'(4));

    // Operands changed during RUN must not affect the result (6*5 = 30).
    do_op(3'd6, 3'd5, 3'd1, 3'd1);

    // Asynchronous reset between edges after E1 aborts the operation.
    start = 1'b1;
    a     = 3'd4;
    b     = 3'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_product", 32'(product), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (W + 2) @(posedge clk);
    #1;
    do_op(3'd2, 3'd3, 3'd7, 3'd7);

    // Exhaustive W=3 sweep.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        do_op(3'(i), 3'(j), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
    end

    // W=4 instance: 15*15 = 225 with W-cycle latency to done.
    start4 = 1'b1;
    a4     = 4'd15;
    b4     = 4'd15;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4     = 4'd0;
    b4     = 4'd0;
    cyc    = 1;
    while (!done4 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("w4_done_seen", 32'(done4), 32'(1));
    check("w4_latency", 32'(cyc - 1), 32'(4));
    check("w4_product", 32'(product4), 32'(225));
    check("w4_busy_in_done", 32'(busy4), 32'(0));
    @(posedge clk);
    #1;
    check("w4_done_single", 32'(done4), 32'(0));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
